// File: rtl/gpio_in_conditioner.sv
`default_nettype none
// ============================================================================
// gpio_in_conditioner
//   Pad input synchroniser, per-bit glitch filter, edge detect, sticky events
//   and maskable interrupt in front of the Microwatt gpio_in port.
//   Revision: 1.0
// ============================================================================
module gpio_in_conditioner #(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             ext_clk,
    input  logic             ext_rst,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] filter_en,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] evt_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] evt_status,
    output logic             irq
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  st_q, st_d;
    logic [WIDTH-1:0]                  st_dly_q, st_dly_d;
    logic [WIDTH-1:0]                  evt_q, evt_d;
    logic [CNT_W-1:0]                  cnt_q [WIDTH];
    logic [CNT_W-1:0]                  cnt_d [WIDTH];
    logic [WIDTH-1:0]                  evt_set;

    assign sync       = sync_q[SYNC_STAGES-1];
    assign rise_pulse = st_q & ~st_dly_q;
    assign fall_pulse = ~st_q & st_dly_q;
    assign evt_set    = (rise_pulse & rise_en) | (fall_pulse & fall_en);

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pad_in};
        st_d     = st_q;
        st_dly_d = st_q;
        // A new event wins over a simultaneous clear so it is never lost.
        evt_d    = evt_set | (evt_q & ~evt_clr);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!filter_en[i]) begin
                st_d[i] = sync[i];
            end else if (sync[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge ext_clk or negedge ext_rst) begin
        if (!ext_rst) begin
            sync_q   <= '0;
            st_q     <= '0;
            st_dly_q <= '0;
            evt_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q   <= sync_d;
            st_q     <= st_d;
            st_dly_q <= st_dly_d;
            evt_q    <= evt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_in    = st_q;
    assign evt_status = evt_q;
    assign irq        = |(evt_q & irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_conditioner.sv
`default_nettype none
// ============================================================================
// tb_gpio_in_conditioner
//   Directed and random stimulus, reference model feeding a scoreboard queue.
//   Revision: 1.0
// ============================================================================
module tb_gpio_in_conditioner;

    localparam int W = 32;
    localparam int S = 2;
    localparam int F = 4;

    logic         ext_clk = 1'b0;
    logic         ext_rst = 1'b0;
    logic [W-1:0] pad_in = '0, filter_en = '0, rise_en = '0, fall_en = '0;
    logic [W-1:0] evt_clr = '0, irq_mask = '0;
    logic [W-1:0] gpio_in, rise_pulse, fall_pulse, evt_status;
    logic         irq;

    gpio_in_conditioner #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
        .ext_clk    (ext_clk),
        .ext_rst    (ext_rst),
        .pad_in     (pad_in),
        .filter_en  (filter_en),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .evt_clr    (evt_clr),
        .irq_mask   (irq_mask),
        .gpio_in    (gpio_in),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .evt_status (evt_status),
        .irq        (irq)
    );

    always #5 ext_clk = ~ext_clk;

    typedef struct packed {
        logic [W-1:0] gpio;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] evt;
        logic         irq;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: pad history, filtered level, previous level, run lengths
    logic [W-1:0] m_hist [S];
    logic [W-1:0] m_st   = '0;
    logic [W-1:0] m_prev = '0;
    logic [W-1:0] m_evt  = '0;
    int           m_run  [W];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input logic rst_v, input logic [W-1:0] pad, input logic [W-1:0] fen,
                        input logic [W-1:0] ren, input logic [W-1:0] fen2,
                        input logic [W-1:0] clr, input logic [W-1:0] msk);
        logic [W-1:0] sync_old, rise_old, fall_old;
        exp_t         e;
        @(negedge ext_clk);
        ext_rst = rst_v; pad_in = pad; filter_en = fen; rise_en = ren;
        fall_en = fen2; evt_clr = clr; irq_mask = msk;
        if (!rst_v) begin
            for (int k = 0; k < S; k++) m_hist[k] = '0;
            for (int b = 0; b < W; b++) m_run[b] = 0;
            m_st = '0; m_prev = '0; m_evt = '0;
        end else begin
            sync_old = m_hist[S-1];
            rise_old = m_st & ~m_prev;
            fall_old = m_prev & ~m_st;
            m_evt    = (rise_old & ren) | (fall_old & fen2) | (m_evt & ~clr);
            m_prev   = m_st;
            for (int b = 0; b < W; b++) begin
                if (!fen[b]) begin
                    m_st[b] = sync_old[b];
                    m_run[b] = 0;
                end else if (sync_old[b] != m_st[b]) begin
                    m_run[b]++;
                    if (m_run[b] >= F) begin
                        m_st[b] = sync_old[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pad;
        end
        e.gpio = m_st;
        e.rise = m_st & ~m_prev;
        e.fall = m_prev & ~m_st;
        e.evt  = m_evt;
        e.irq  = |(m_evt & msk);
        sb_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge ext_clk);
        #1;
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        @(negedge ext_clk);
        forever begin
            @(posedge ext_clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=0 required=1");
            end else begin
                e = sb_q.pop_front();
                chk("gpio_in", gpio_in, e.gpio);
                chk("rise_pulse", rise_pulse, e.rise);
                chk("fall_pulse", fall_pulse, e.fall);
                chk("evt_status", evt_status, e.evt);
                chk("irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, e.irq});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    logic [W-1:0] pad, fen, ren, fen2, msk, clr;
    logic         rstv;

    initial begin
        for (int k = 0; k < S; k++) m_hist[k] = '0;
        for (int b = 0; b < W; b++) m_run[b] = 0;

        // Reset with pads high, then release in bypass
        step(1'b0, '1, '0, '0, '0, '0, '1);
        step(1'b0, '1, '0, '0, '0, '0, '1);
        after_edge();
        chk("rst_gpio", gpio_in, '0);
        chk("rst_irq", {{(W-1){1'b0}}, irq}, '0);
        step(1'b1, '1, '0, '0, '0, '0, '1);
        step(1'b1, '1, '0, '0, '0, '0, '1);
        step(1'b1, '1, '0, '0, '0, '0, '1);
        after_edge();
        chk("rel_gpio_3rd", gpio_in, '1);
        chk("rel_rise_3rd", rise_pulse, '1);
        step(1'b1, '1, '0, '0, '0, '0, '1);
        after_edge();
        chk("rel_rise_4th", rise_pulse, '0);

        // Bring pads low, then bypass rise on bit 0 with event/irq enabled
        for (int c = 0; c < 4; c++) step(1'b1, '0, '0, '0, '0, '1, '0);
        for (int c = 0; c < 5; c++) step(1'b1, 32'h1, '0, 32'h1, '0, '0, 32'h1);
        after_edge();
        chk("bit0_irq", {{(W-1){1'b0}}, irq}, 32'h1);

        // Glitch on filtered bit 5: 3 cycles rejected, then a long high accepted
        for (int c = 0; c < 3; c++) step(1'b1, 32'h20, 32'h20, '1, '1, '1, '0);
        for (int c = 0; c < 8; c++) step(1'b1, 32'h0, 32'h20, '1, '1, '1, '0);
        after_edge();
        chk("glitch_reject", gpio_in & 32'h20, '0);
        for (int c = 0; c < 6; c++) step(1'b1, 32'h20, 32'h20, '1, '1, '0, '0);
        after_edge();
        chk("glitch_accept_6th", gpio_in & 32'h20, 32'h20);

        // Falling-only event on bit 7, then clear
        for (int c = 0; c < 5; c++) step(1'b1, 32'hA0, 32'h20, 32'h0, 32'h80, '1, 32'h80);
        for (int c = 0; c < 5; c++) step(1'b1, 32'h20, 32'h20, 32'h0, 32'h80, '0, 32'h80);
        after_edge();
        chk("fall_evt7", evt_status & 32'h80, 32'h80);
        step(1'b1, 32'h20, 32'h20, 32'h0, 32'h80, 32'h80, 32'h80);
        step(1'b1, 32'h20, 32'h20, 32'h0, 32'h80, 32'h0, 32'h80);
        after_edge();
        chk("clr_evt7", evt_status & 32'h80, '0);

        // Set/clear collision on bit 2: clear lands on the edge that sees rise_pulse
        for (int c = 0; c < 6; c++)
            step(1'b1, 32'h24, 32'h20, 32'h4, '0, (c == 3) ? 32'h4 : 32'h0, '0);
        after_edge();
        chk("collision_evt2", evt_status & 32'h4, 32'h4);

        // Reset in the middle of a filter count on bit 9
        for (int c = 0; c < 4; c++) step(1'b1, 32'h0, 32'h0, '0, '0, '1, '0);
        for (int c = 0; c < 4; c++) step(1'b1, 32'h200, 32'h200, '0, '0, '0, '0);
        step(1'b0, 32'h200, 32'h200, '0, '0, '0, '0);
        step(1'b0, 32'h200, 32'h200, '0, '0, '0, '0);
        for (int c = 0; c < 5; c++) step(1'b1, 32'h200, 32'h200, '0, '0, '0, '0);
        after_edge();
        chk("midrst_5th", gpio_in & 32'h200, '0);
        step(1'b1, 32'h200, 32'h200, '0, '0, '0, '0);
        after_edge();
        chk("midrst_6th", gpio_in & 32'h200, 32'h200);

        // Random traffic
        pad = 32'h200; fen = '0; ren = '1; fen2 = '1; msk = '1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) fen = $urandom;
            if (c % 40 == 0) begin
                ren  = $urandom;
                fen2 = $urandom;
                msk  = $urandom;
            end
            pad  = pad ^ ($urandom & $urandom & $urandom & $urandom);
            clr  = $urandom & $urandom & $urandom;
            rstv = ($urandom_range(0, 499) != 0);
            step(rstv, pad, fen, ren, fen2, clr, msk);
        end

        @(posedge ext_clk);
        #2;
        chk("sb_drained", W'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
